// File: rtl/wb_pkg.sv
// wb_pkg: shared types for the writeback stage (load-size codes, buffer entry, FSM states, forward match helper)
package wb_pkg;
    localparam logic [1:0] LS_WORD = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_BYTE = 2'b10;
    localparam logic [1:0] LS_RSVD = 2'b11;
    localparam int DEPTH = 2;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } wb_state_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        regwrite;
    } wb_entry_t;

    function automatic logic fwd_match(input wb_entry_t e, input logic v, input logic [4:0] a);
        return v && e.regwrite && (e.rd != 5'd0) && (e.rd == a);
    endfunction
endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: selects and extends the addressed word/half/byte of a load result
module wb_load_align
    import wb_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);
    logic [15:0] half_v;
    logic [7:0]  byte_v;

    always_comb begin
        half_v = off_i[1] ? data_i[31:16] : data_i[15:0];
        byte_v = data_i[{off_i, 3'b000} +: 8];
        data_o = (size_i == LS_WORD || size_i == LS_RSVD) ? data_i
               : (size_i == LS_HALF) ? {{16{signed_i & half_v[15]}}, half_v}
               : {{24{signed_i & byte_v[7]}}, byte_v};
    end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: 2-entry in-order retire buffer driving the register-file write port
// Optional combinational forwarding lookup when WB_FWD_EN is defined.
module writeback_stage
    import wb_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    input  logic [1:0]  LoadSize_i,
    input  logic        LoadSigned_i,
    input  logic [1:0]  ByteOff_i,
    input  logic [31:0] ALUres_i,
    input  logic [31:0] MemData_i,
    input  logic [4:0]  RDaddr_i,
    input  logic        wb_hold_i,
`ifdef WB_FWD_EN
    input  logic [4:0]  fwd_rs_i,
    input  logic [4:0]  fwd_rt_i,
    output logic        fwd_rs_hit_o,
    output logic [31:0] fwd_rs_data_o,
    output logic        fwd_rt_hit_o,
    output logic [31:0] fwd_rt_data_o,
`endif
    output logic [4:0]  RDaddr_o,
    output logic [31:0] RDdata_o,
    output logic        RegWrite_o
);
    wb_state_e   state_q, state_d;
    wb_entry_t   ent_q [DEPTH];
    wb_entry_t   ent_d [DEPTH];
    wb_entry_t   new_e;
    logic [31:0] load_data;
    logic        head_valid, accept, retire;

    wb_load_align u_align (
        .size_i   (LoadSize_i),
        .signed_i (LoadSigned_i),
        .off_i    (ByteOff_i),
        .data_i   (MemData_i),
        .data_o   (load_data)
    );

    // Slot 0 is always the head; slot 1 only holds data in FULL.
    always_comb begin
        head_valid = state_q != ST_EMPTY;
        ready_o    = state_q != ST_FULL;
        accept     = valid_i && ready_o;
        retire     = head_valid && !wb_hold_i;
        new_e      = '{rd: RDaddr_i, data: MemtoReg_i ? load_data : ALUres_i, regwrite: RegWrite_i};
        state_d    = state_q;
        ent_d      = ent_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    ent_d[0] = new_e;
                    state_d  = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && retire) begin
                    ent_d[0] = new_e;
                end else if (accept) begin
                    ent_d[1] = new_e;
                    state_d  = ST_FULL;
                end else if (retire) begin
                    state_d  = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (retire) begin
                    ent_d[0] = ent_q[1];
                    state_d  = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_EMPTY;
            ent_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            ent_q   <= ent_d;
        end
    end

    assign RDaddr_o   = ent_q[0].rd;
    assign RDdata_o   = ent_q[0].data;
    assign RegWrite_o = retire && ent_q[0].regwrite && (ent_q[0].rd != 5'd0);

`ifdef WB_FWD_EN
    logic rs0, rs1, rt0, rt1;

    // Slot 1 is younger than slot 0, so it takes priority.
    always_comb begin
        rs1           = fwd_match(ent_q[1], state_q == ST_FULL, fwd_rs_i);
        rs0           = fwd_match(ent_q[0], head_valid, fwd_rs_i);
        rt1           = fwd_match(ent_q[1], state_q == ST_FULL, fwd_rt_i);
        rt0           = fwd_match(ent_q[0], head_valid, fwd_rt_i);
        fwd_rs_hit_o  = rs0 | rs1;
        fwd_rt_hit_o  = rt0 | rt1;
        fwd_rs_data_o = rs1 ? ent_q[1].data : rs0 ? ent_q[0].data : '0;
        fwd_rt_data_o = rt1 ? ent_q[1].data : rt0 ? ent_q[0].data : '0;
    end
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: scoreboard bench for writeback_stage (forwarding checks when WB_FWD_EN is defined)
module tb_writeback_stage;
    logic        clk = 1'b0;
    logic        rst_n_i, valid_i, ready_o, RegWrite_i, MemtoReg_i, LoadSigned_i, wb_hold_i;
    logic [1:0]  LoadSize_i, ByteOff_i;
    logic [31:0] ALUres_i, MemData_i, RDdata_o;
    logic [4:0]  RDaddr_i, RDaddr_o;
    logic        RegWrite_o;
`ifdef WB_FWD_EN
    logic [4:0]  fwd_rs_i, fwd_rt_i;
    logic        fwd_rs_hit_o, fwd_rt_hit_o;
    logic [31:0] fwd_rs_data_o, fwd_rt_data_o;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int prev_wr = -10;
    int last_wr = -10;
    logic [36:0] sb[$];

    logic [1:0]  t_sz  [4] = '{2'b10, 2'b10, 2'b01, 2'b00};
    logic [1:0]  t_off [4] = '{2'd3, 2'd3, 2'd2, 2'd1};
    logic        t_sg  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] t_exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h80FF7F01};

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .RegWrite_i   (RegWrite_i),
        .MemtoReg_i   (MemtoReg_i),
        .LoadSize_i   (LoadSize_i),
        .LoadSigned_i (LoadSigned_i),
        .ByteOff_i    (ByteOff_i),
        .ALUres_i     (ALUres_i),
        .MemData_i    (MemData_i),
        .RDaddr_i     (RDaddr_i),
        .wb_hold_i    (wb_hold_i),
`ifdef WB_FWD_EN
        .fwd_rs_i     (fwd_rs_i),
        .fwd_rt_i     (fwd_rt_i),
        .fwd_rs_hit_o (fwd_rs_hit_o),
        .fwd_rs_data_o(fwd_rs_data_o),
        .fwd_rt_hit_o (fwd_rt_hit_o),
        .fwd_rt_data_o(fwd_rt_data_o),
`endif
        .RDaddr_o     (RDaddr_o),
        .RDdata_o     (RDdata_o),
        .RegWrite_o   (RegWrite_o)
    );

    function automatic logic [31:0] exp_data(input logic mtr, input logic [1:0] sz, input logic sg,
                                             input logic [1:0] off, input logic [31:0] alu, input logic [31:0] md);
        logic [31:0] v;
        if (!mtr) return alu;
        if (sz == 2'b01) begin
            v = md >> (off[1] ? 16 : 0);
            return (sg && v[15]) ? (v | 32'hFFFF0000) : (v & 32'h0000FFFF);
        end
        if (sz == 2'b10) begin
            v = md >> (8 * int'(off));
            return (sg && v[7]) ? (v | 32'hFFFFFF00) : (v & 32'h000000FF);
        end
        return md;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic [36:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (RegWrite_o === 1'b1) begin
                prev_wr = last_wr;
                last_wr = cyc;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got rd=%0d data=%h, required no write", RDaddr_o, RDdata_o);
                end else begin
                    e = sb.pop_front();
                    if ({RDaddr_o, RDdata_o} !== e) begin
                        errors++;
                        $display("FAIL write_data: got rd=%0d data=%h, required rd=%0d data=%h",
                                 RDaddr_o, RDdata_o, e[36:32], e[31:0]);
                    end
                end
            end
        end
    endtask

    // Call only just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic mtr, input logic rw, input logic [1:0] sz, input logic [1:0] off,
                        input logic sg, input logic [31:0] alu, input logic [31:0] md, input logic [4:0] rd);
        int n = 0;
        MemtoReg_i = mtr; RegWrite_i = rw; LoadSize_i = sz; ByteOff_i = off;
        LoadSigned_i = sg; ALUres_i = alu; MemData_i = md; RDaddr_i = rd;
        valid_i = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (ready_o !== 1'b1 && n < 50);
        if (ready_o !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ready_o=%b after %0d cycles, required 1", ready_o, n);
        end else if (rw && rd != 5'd0) begin
            sb.push_back({rd, exp_data(mtr, sz, sg, off, alu, md)});
        end
        step();
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d writes outstanding, required 0", sb.size());
        end
        step();
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; valid_i = 1'b0; wb_hold_i = 1'b0; RegWrite_i = 1'b0; MemtoReg_i = 1'b0;
        LoadSize_i = 2'b00; LoadSigned_i = 1'b0; ByteOff_i = 2'b00; ALUres_i = '0; MemData_i = '0; RDaddr_i = '0;
`ifdef WB_FWD_EN
        fwd_rs_i = '0; fwd_rt_i = '0;
`endif
        #12;
        checks += 4;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", ready_o); end
        if (RegWrite_o !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b required 0", RegWrite_o); end
        if (RDaddr_o !== 5'd0) begin errors++; $display("FAIL reset_rdaddr: got %0d required 0", RDaddr_o); end
        if (RDdata_o !== 32'd0) begin errors++; $display("FAIL reset_rddata: got %h required 0", RDdata_o); end
        @(negedge clk);
        rst_n_i = 1'b1;
        step();
    endtask

    task automatic test_word_load();
        send(1'b1, 1'b1, 2'b00, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 5'd8);
        @(negedge clk);
        checks++;
        if (RegWrite_o !== 1'b1 || RDaddr_o !== 5'd8 || RDdata_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL word_latency: got we=%b rd=%0d data=%h, required we=1 rd=8 data=deadbeef",
                     RegWrite_o, RDaddr_o, RDdata_o);
        end
        @(negedge clk);
        checks++;
        if (RegWrite_o !== 1'b0) begin errors++; $display("FAIL word_pulse: got we=%b required 0", RegWrite_o); end
        drain();
    endtask

    task automatic test_loads();
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 1'b1, t_sz[i], t_off[i], t_sg[i], 32'h0, 32'h80FF7F01, 5'(i + 1));
            @(negedge clk);
            checks++;
            if (RegWrite_o !== 1'b1 || RDdata_o !== t_exp[i]) begin
                errors++;
                $display("FAIL load_align_%0d: got we=%b data=%h, required we=1 data=%h", i, RegWrite_o, RDdata_o, t_exp[i]);
            end
            step();
        end
        for (int i = 0; i < 24; i++)
            send(1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(1, 31)));
        drain();
    endtask

    task automatic test_rd0();
        send(1'b0, 1'b1, 2'b00, 2'd0, 1'b0, 32'h1234, 32'h0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (RegWrite_o !== 1'b0) begin errors++; $display("FAIL rd0_write: cycle %0d got we=%b required 0", i, RegWrite_o); end
        end
        checks++;
        if (RDdata_o !== 32'h1234) begin errors++; $display("FAIL rd0_head: got data=%h required 00001234", RDdata_o); end
        step();
    endtask

    task automatic test_hold();
        wb_hold_i = 1'b1;
        send(1'b0, 1'b1, 2'b00, 2'd0, 1'b0, 32'hAAAA0001, 32'h0, 5'd10);
        send(1'b0, 1'b1, 2'b00, 2'd0, 1'b0, 32'hBBBB0002, 32'h0, 5'd11);
        RDaddr_i = 5'd12; ALUres_i = 32'hCCCC0003; valid_i = 1'b1;
        @(negedge clk);
        checks += 2;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL hold_full_ready: got %b required 0", ready_o); end
        if (RegWrite_o !== 1'b0) begin errors++; $display("FAIL hold_write: got %b required 0", RegWrite_o); end
        step();
        wb_hold_i = 1'b0;
        send(1'b0, 1'b1, 2'b00, 2'd0, 1'b0, 32'hCCCC0003, 32'h0, 5'd12);
        checks++;
        if (last_wr != prev_wr + 1) begin
            errors++;
            $display("FAIL hold_consecutive: writes at cycles %0d and %0d, required adjacent", prev_wr, last_wr);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        fork
            begin
                repeat (60) begin
                    step();
                    wb_hold_i = ($urandom_range(0, 2) == 0);
                end
                wb_hold_i = 1'b0;
            end
            begin
                for (int i = 0; i < 16; i++)
                    send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                         2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                         5'($urandom_range(0, 31)));
            end
        join
        drain();
    endtask

`ifdef WB_FWD_EN
    task automatic test_fwd();
        wb_hold_i = 1'b1;
        send(1'b0, 1'b1, 2'b00, 2'd0, 1'b0, 32'h11, 32'h0, 5'd5);
        send(1'b0, 1'b1, 2'b00, 2'd0, 1'b0, 32'h22, 32'h0, 5'd5);
        fwd_rs_i = 5'd5; fwd_rt_i = 5'd0;
        @(negedge clk);
        checks += 3;
        if (fwd_rs_hit_o !== 1'b1 || fwd_rs_data_o !== 32'h22) begin
            errors++;
            $display("FAIL fwd_youngest: got hit=%b data=%h required hit=1 data=22", fwd_rs_hit_o, fwd_rs_data_o);
        end
        if (fwd_rt_hit_o !== 1'b0) begin errors++; $display("FAIL fwd_zero: got hit=%b required 0", fwd_rt_hit_o); end
        fwd_rt_i = 5'd6;
        #1;
        if (fwd_rt_hit_o !== 1'b0) begin errors++; $display("FAIL fwd_miss: got hit=%b required 0", fwd_rt_hit_o); end
        step();
        wb_hold_i = 1'b0;
        drain();
        checks++;
        fwd_rs_i = 5'd5;
        #1;
        if (fwd_rs_hit_o !== 1'b0) begin errors++; $display("FAIL fwd_empty: got hit=%b required 0", fwd_rs_hit_o); end
        fwd_rs_i = 5'd0; fwd_rt_i = 5'd0;
        step();
    endtask
`endif

    task automatic test_async_reset();
        wb_hold_i = 1'b1;
        send(1'b0, 1'b1, 2'b00, 2'd0, 1'b0, 32'h5555, 32'h0, 5'd20);
        send(1'b0, 1'b1, 2'b00, 2'd0, 1'b0, 32'h6666, 32'h0, 5'd21);
        wb_hold_i = 1'b0;
        #1;
        checks++;
        if (RegWrite_o !== 1'b1) begin errors++; $display("FAIL pre_reset_write: got we=%b required 1", RegWrite_o); end
        #1;
        rst_n_i = 1'b0;
        sb.delete();
        #1;
        checks += 4;
        if (RegWrite_o !== 1'b0) begin errors++; $display("FAIL async_regwrite: got %b required 0", RegWrite_o); end
        if (RDaddr_o !== 5'd0) begin errors++; $display("FAIL async_rdaddr: got %0d required 0", RDaddr_o); end
        if (RDdata_o !== 32'd0) begin errors++; $display("FAIL async_rddata: got %h required 0", RDdata_o); end
        if (ready_o !== 1'b1) begin errors++; $display("FAIL async_ready: got %b required 1", ready_o); end
        step();
        step();
        @(negedge clk);
        rst_n_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (RegWrite_o !== 1'b0) begin errors++; $display("FAIL post_reset_write: cycle %0d got %b required 0", i, RegWrite_o); end
        end
        step();
        send(1'b0, 1'b1, 2'b00, 2'd0, 1'b0, 32'h7777, 32'h0, 5'd22);
        drain();
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_word_load();
        test_loads();
        test_rd0();
        test_hold();
        test_back_to_back();
`ifdef WB_FWD_EN
        test_fwd();
`endif
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
